dbg_mem_reader: RTL and testbench

JTAG debug memory read engine, the read-side counterpart of the JTAG memory write path (mem_we_o/mem_addr_o/mem_wdata_o).
- Accepts burst read requests from the debug module and issues word reads to the shared data RAM through an arbitration grant.
- Extracts and sign/zero-extends byte, half and word lanes, then returns one response beat per element under a valid/ready handshake.
- Sits in riscv_soc between jtag_top and the RAM port mux; the core has priority at the mux.

---
 rtl/dbg_mem_reader_pkg.sv | 31 +++
 rtl/dbg_rd_lane_extract.sv | 25 ++
 rtl/dbg_mem_reader.sv | 163 ++++++++++++++++
 tb/tb_dbg_mem_reader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_mem_reader_pkg.sv
// Shared size codes, FSM encoding and alignment rule for the debug read engine.
// Optional range check is enabled in the top with DBG_RD_RANGE_CHECK_EN.
package dbg_mem_reader_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic bad;
        unique case (size)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = off[0];
            MEM_W:   bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dbg_rd_lane_extract.sv
// Little-endian byte/half/word lane select with sign or zero extension.
module dbg_rd_lane_extract
    import dbg_mem_reader_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        unique case (size)
            MEM_B:   data = {{24{sign & b[7]}}, b};
            MEM_H:   data = {{16{sign & h[15]}}, h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dbg_mem_reader.sv
// JTAG debug burst memory read engine; one RAM word read per response beat.
// Define DBG_RD_RANGE_CHECK_EN to flag beats at or above MEM_BYTES as errors.
module dbg_mem_reader
    import dbg_mem_reader_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int LEN_W     = 8,
    parameter int MEM_BYTES = 32768
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_sign,
    input  logic [LEN_W-1:0] req_len,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [DW-1:0]    resp_data,
    output logic             resp_err,
    output logic             resp_last,
    output logic             ram_req,
    input  logic             ram_gnt,
    output logic             ram_ren,
    output logic [AW-1:0]    ram_addr,
    input  logic [DW-1:0]    ram_rdata,
    output logic             busy
);

`ifdef DBG_RD_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif
    localparam logic [AW-1:0] MEM_LIM = AW'(MEM_BYTES);

    state_t           state;
    logic [AW-1:0]    addr;
    logic [AW-1:0]    next_addr;
    logic [1:0]       size;
    logic             sign;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
    logic [DW-1:0]    lane;

    function automatic logic illegal(
        input logic [AW-1:0] a,
        input logic [1:0]    s
    );
        return misaligned(s, a[1:0]) || (RANGE_CHK && (a >= MEM_LIM));
    endfunction

    assign next_addr = addr + (AW'(1) << size);
    assign ram_ren   = ram_req & ram_gnt;

    dbg_rd_lane_extract u_lane (
        .word   (ram_rdata),
        .offset (addr[1:0]),
        .size   (size),
        .sign   (sign),
        .data   (lane)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            ram_req    <= 1'b0;
            ram_addr   <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            resp_last  <= 1'b0;
            addr       <= '0;
            size       <= MEM_B;
            sign       <= 1'b0;
            len        <= '0;
            cnt        <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr      <= req_addr;
                        size      <= req_size;
                        sign      <= req_sign;
                        len       <= req_len;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (illegal(req_addr, req_size)) begin
                            state      <= S_ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                            resp_last  <= 1'b1;
                        end else begin
                            state    <= S_ISSUE;
                            ram_req  <= 1'b1;
                            ram_addr <= {req_addr[AW-1:2], 2'b00};
                        end
                    end
                end
                S_ISSUE: begin
                    if (ram_gnt) begin
                        ram_req <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    resp_data  <= lane;
                    resp_err   <= 1'b0;
                    resp_last  <= (cnt == len);
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_last  <= 1'b0;
                        if (resp_last) begin
                            state     <= S_IDLE;
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            addr <= next_addr;
                            cnt  <= cnt + LEN_W'(1);
                            if (illegal(next_addr, size)) begin
                                state      <= S_ERR;
                                resp_valid <= 1'b1;
                                resp_err   <= 1'b1;
                                resp_data  <= '0;
                                resp_last  <= 1'b1;
                            end else begin
                                state    <= S_ISSUE;
                                ram_req  <= 1'b1;
                                ram_addr <= {next_addr[AW-1:2], 2'b00};
                            end
                        end
                    end
                end
                S_ERR: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_last  <= 1'b0;
                        state      <= S_IDLE;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_mem_reader.sv
// Bench for dbg_mem_reader: burst model, per-cycle compare, directed reads.
// Build with DBG_RD_RANGE_CHECK_EN to cover the range-check variant.
module tb_dbg_mem_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_sign = 1'b0;
    logic [7:0]  req_len = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        resp_last;
    logic        ram_req;
    logic        ram_gnt = 1'b1;
    logic        ram_ren;
    logic [31:0] ram_addr;
    logic [31:0] ram_rdata = '0;
    logic        busy;

    dbg_mem_reader dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_len    (req_len),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .resp_last  (resp_last),
        .ram_req    (ram_req),
        .ram_gnt    (ram_gnt),
        .ram_ren    (ram_ren),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // RAM: 8192 words, aliases on index bits, one cycle read latency
    logic [31:0] mem [0:8191];
    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= mem[ram_addr[14:2]];
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] addr_q[$];

    int checks = 0;
    int errors = 0;

    int t_acc, t_ren, t_resp;
    bit got_ren, got_resp;
    int req_cnt = 0;
    int n_beats = 0;
    logic [31:0] last_data;
    logic        last_err;
    logic        last_last;
    logic [31:0] last_ren_addr;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic m_illegal(logic [31:0] a, logic [1:0] s);
        if (s == 2'b11) return 1'b1;
        if (s == 2'b01 && a[0]) return 1'b1;
        if (s == 2'b10 && a[1:0] != 2'b00) return 1'b1;
`ifdef DBG_RD_RANGE_CHECK_EN
        if (a >= 32'd32768) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_data(
        logic [31:0] w, logic [31:0] a, logic [1:0] s, logic sg
    );
        logic [31:0] v;
        if (s == 2'b10) return w;
        if (s == 2'b00) begin
            v = (w >> (8 * a[1:0])) & 32'h0000_00FF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else begin
            v = (w >> (16 * a[1])) & 32'h0000_FFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Expected beats for a whole burst, built at acceptance time
    task automatic model_burst(
        logic [31:0] a0, logic [1:0] s, logic sg, logic [7:0] l
    );
        beat_t b;
        logic [31:0] a;
        for (int i = 0; i <= int'(l); i++) begin
            a = a0 + (32'(i) << s);
            if (m_illegal(a, s)) begin
                b.data = 32'h0;
                b.err  = 1'b1;
                b.last = 1'b1;
                exp_q.push_back(b);
                break;
            end
            addr_q.push_back({a[31:2], 2'b00});
            b.data = m_data(mem[a[14:2]], a, s, sg);
            b.err  = 1'b0;
            b.last = (i == int'(l));
            exp_q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            addr_q.delete();
        end else begin
            if (req_valid && req_ready) begin
                model_burst(req_addr, req_size, req_sign, req_len);
                t_acc    = cyc;
                got_ren  = 1'b0;
                got_resp = 1'b0;
            end
            if (ram_req) req_cnt++;
            if (ram_ren) begin
                if (!got_ren) begin
                    t_ren   = cyc;
                    got_ren = 1'b1;
                end
                last_ren_addr = ram_addr;
                if (addr_q.size() == 0)
                    chk("unexpected_ram_read", {31'b0, ram_ren}, 32'd0);
                else
                    chk("ram_addr", ram_addr, addr_q.pop_front());
            end
            if (resp_valid) begin
                if (!got_resp) begin
                    t_resp   = cyc;
                    got_resp = 1'b1;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {31'b0, resp_valid}, 32'd0);
                end else begin
                    chk("resp_data", resp_data, exp_q[0].data);
                    chk("resp_err", {31'b0, resp_err}, {31'b0, exp_q[0].err});
                    chk("resp_last", {31'b0, resp_last}, {31'b0, exp_q[0].last});
                    if (resp_ready) begin
                        last_data = resp_data;
                        last_err  = resp_err;
                        last_last = resp_last;
                        n_beats++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_req(
        logic [31:0] a, logic [1:0] s, logic sg, logic [7:0] l
    );
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = a;
        req_size  = s;
        req_sign  = sg;
        req_len   = l;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 50);
        if (!req_ready) chk("req_accept_timeout", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("done_timeout", {31'b0, busy}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0, nb0, n;
        for (int i = 0; i < 8192; i++) mem[i] = 32'h5A5A_0000 | 32'(i);
        mem[0]      = 32'hCAFE_0001;
        mem[13'h40] = 32'h8765_43A1;
        mem[13'h7F] = 32'hF0E0_D0C0;
        mem[13'h80] = 32'd1;
        mem[13'h81] = 32'd2;
        mem[13'h82] = 32'd3;
        mem[13'h83] = 32'd4;
        mem[13'hC0] = 32'h0BAD_F00D;
        mem[13'h1FFF] = 32'h1234_5678;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_ram_req", {31'b0, ram_req}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: word read and latency
        do_req(32'h100, 2'b10, 1'b0, 8'd0);
        wait_done();
        chk("t1_data", last_data, 32'h8765_43A1);
        chk("t1_last", {31'b0, last_last}, 32'd1);
        chk("t1_ren_lat", t_ren - t_acc, 32'd1);
        chk("t1_resp_lat", t_resp - t_acc, 32'd3);

        // 2: lane extraction
        do_req(32'h100, 2'b00, 1'b1, 8'd0);
        wait_done();
        chk("t2_b_sext", last_data, 32'hFFFF_FFA1);
        do_req(32'h102, 2'b01, 1'b0, 8'd0);
        wait_done();
        chk("t2_h_zext", last_data, 32'h0000_8765);
        do_req(32'h102, 2'b01, 1'b1, 8'd0);
        wait_done();
        chk("t2_h_sext", last_data, 32'hFFFF_8765);
        do_req(32'h103, 2'b00, 1'b0, 8'd0);
        wait_done();
        chk("t2_b3_zext", last_data, 32'h0000_0087);

        // 3: word burst with stall on beat 1
        nb0 = n_beats;
        resp_ready = 1'b0;
        do_req(32'h200, 2'b10, 1'b0, 8'd3);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        resp_ready = 1'b1;
        wait_done();
        chk("t3_beats", n_beats - nb0, 32'd4);
        chk("t3_last_data", last_data, 32'd4);

        // Byte burst crossing a word boundary
        do_req(32'h1FE, 2'b00, 1'b1, 8'd3);
        wait_done();
        chk("t3b_last_byte", last_data, 32'h0000_0000);

        // 4: misaligned half, no RAM traffic
        rc0 = req_cnt;
        do_req(32'h101, 2'b01, 1'b0, 8'd2);
        wait_done();
        chk("t4_err", {31'b0, last_err}, 32'd1);
        chk("t4_no_ram_req", req_cnt - rc0, 32'd0);
        do_req(32'h100, 2'b11, 1'b0, 8'd0);
        wait_done();
        chk("t4_size11_err", {31'b0, last_err}, 32'd1);

        // 5: grant withheld for 5 cycles
        ram_gnt = 1'b0;
        do_req(32'h300, 2'b10, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_req_hold", {31'b0, ram_req}, 32'd1);
            chk("t5_no_ren", {31'b0, ram_ren}, 32'd0);
            chk("t5_addr_hold", ram_addr, 32'h300);
        end
        @(posedge clk); #1;
        ram_gnt = 1'b1;
        wait_done();
        chk("t5_data", last_data, 32'h0BAD_F00D);

        // Reset during WAIT abandons the burst
        do_req(32'h100, 2'b10, 1'b0, 8'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("t5_rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("t5_rst_busy", {31'b0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        chk("t5_rst_no_beat", {31'b0, resp_valid}, 32'd0);

        // 6: read at MEM_BYTES
        rc0 = req_cnt;
        do_req(32'h8000, 2'b10, 1'b0, 8'd0);
        wait_done();
`ifdef DBG_RD_RANGE_CHECK_EN
        chk("t6_err", {31'b0, last_err}, 32'd1);
        chk("t6_no_ram_req", req_cnt - rc0, 32'd0);
`else
        chk("t6_ren_addr", last_ren_addr, 32'h8000);
        chk("t6_alias_data", last_data, 32'hCAFE_0001);
`endif

        // Burst walking off the end of RAM
        do_req(32'h7FFC, 2'b10, 1'b0, 8'd1);
        wait_done();
`ifdef DBG_RD_RANGE_CHECK_EN
        chk("t6b_err", {31'b0, last_err}, 32'd1);
`else
        chk("t6b_alias", last_data, 32'hCAFE_0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
